axi_lite_led_regs: RTL

- AXI4-Lite slave (responder) on the PS GP0 master port; provides the LED output register plus scratch, ID and cycle-counter registers.
- Accepts single-beat reads and writes from the PS master, applies byte strobes, and returns OKAY or SLVERR.
- Drives the board LED pins directly.

---
 rtl/axi_lite_led_regs.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_led_regs.sv
// AXI4-Lite register slave: LED output, scratch, ID and free-running cycle counter.
// Write and read channels run independently; one transaction in flight per channel.
module axi_lite_led_regs #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          LED_WIDTH  = 4,
  parameter logic [31:0] ID_VALUE   = 32'h4C454430
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [LED_WIDTH-1:0]  led_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [LED_WIDTH-1:0]  led_q;
  logic [31:0]           scratch_q, cnt_q, led32;

  // AW/W captured when one arrives before the other
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;

  logic                  aw_hs, w_hs, have_aw, have_w, wr_commit, wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data, wr_merged;
  logic [3:0]            wr_strb;
  logic [1:0]            wr_sel;
  logic [31:0]           rd_data;
  logic [1:0]            rd_resp;
  logic                  unused_addr_bits;

  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Zero-extend LED for reads and byte merging
  always_comb begin
    led32 = '0;
    led32[LED_WIDTH-1:0] = led_q;
  end

  // Commit happens on the edge where the later of AW/W completes; merge held and live halves
  always_comb begin
    aw_hs     = s_axi_awvalid & s_axi_awready;
    w_hs      = s_axi_wvalid & s_axi_wready;
    have_aw   = aw_held | aw_hs;
    have_w    = w_held | w_hs;
    wr_commit = (w_state == W_IDLE) & have_aw & have_w;
    wr_addr   = aw_held ? aw_addr_q : s_axi_awaddr;
    wr_data   = w_held ? w_data_q : s_axi_wdata;
    wr_strb   = w_held ? w_strb_q : s_axi_wstrb;
    wr_sel    = wr_addr[3:2];
    wr_ok     = (wr_addr[ADDR_WIDTH-1:4] == '0) && (wr_sel != 2'd2);
    wr_merged = strb_merge((wr_sel == 2'd0) ? led32 : scratch_q, wr_data, wr_strb);
  end

  assign unused_addr_bits = ^{wr_addr[1:0], s_axi_araddr[1:0]};

  // Read decode from the live AR address; registered on the AR handshake
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (s_axi_araddr[ADDR_WIDTH-1:4] == '0) begin
      case (s_axi_araddr[3:2])
        2'd0:    rd_data = led32;
        2'd1:    rd_data = scratch_q;
        2'd2:    rd_data = ID_VALUE;
        default: rd_data = cnt_q;
      endcase
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  // Register file: counter free-runs, a CNT write (any byte enabled) overrides the increment
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      led_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (wr_commit && wr_ok) begin
        case (wr_sel)
          2'd0:    led_q     <= wr_merged[LED_WIDTH-1:0];
          2'd1:    scratch_q <= wr_merged;
          default: if (|wr_strb) cnt_q <= '0;
        endcase
      end
    end
  end

  assign led_o = led_q;

  // Write channel FSM: independent AW/W capture, commit, hold B until BREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
          end
          s_axi_awready <= !have_aw;
          s_axi_wready  <= !have_w;
          if (wr_commit) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            w_state      <= W_RESP;
          end
        end
        default: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read channel FSM: register data on AR handshake, hold until RREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rdata   <= rd_data;
            s_axi_rresp   <= rd_resp;
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        default: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule
